window_3x3_linebuf: RTL

Streaming 3x3 window generator for the rank-order/median filter datapath. It accepts an 8-bit grayscale image in raster order, one pixel per handshake, and buffers two image lines internally. For every pixel it emits the full 3x3 neighbourhood, with out-of-image taps zero-padded. Its outputs feed the nine `iNumN` inputs of `rank_order` directly, replacing random RAM addressing with a single sequential pixel read stream.

---
 rtl/window_3x3_linebuf.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/window_3x3_linebuf.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 tap array,
// emitting one zero-padded neighbourhood per raster pixel.
// Optional build macro WIN_REPLICATE_EN: masked taps take the centre pixel
// value instead of zero.
module window_3x3_linebuf #(
   parameter int unsigned IMG_W = 64,
   parameter int unsigned IMG_H = 64,
   parameter int unsigned CW    = 6
) (
   input  logic          iClk,
   input  logic          iRst_n,
   input  logic          iValid,
   input  logic [7:0]    iPixel,
   output logic          oReady,
   output logic [7:0]    oP11,
   output logic [7:0]    oP12,
   output logic [7:0]    oP13,
   output logic [7:0]    oP21,
   output logic [7:0]    oP22,
   output logic [7:0]    oP23,
   output logic [7:0]    oP31,
   output logic [7:0]    oP32,
   output logic [7:0]    oP33,
   output logic [CW-1:0] oRow,
   output logic [CW-1:0] oCol,
   output logic          oValid,
   output logic          oDone
);

   localparam int unsigned AW = $clog2(IMG_W);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t        state;
   logic [7:0]    lineA [IMG_W];   // sample from one line earlier
   logic [7:0]    lineB [IMG_W];   // sample from two lines earlier
   logic [7:0]    tapA [3];        // oldest stored window column
   logic [7:0]    tapB [3];        // middle stored window column
   logic [CW-1:0] inRow;
   logic [CW-1:0] inCol;
   logic [CW-1:0] cRow;
   logic [CW-1:0] cCol;

   logic          accept;
   logic          advance;
   logic          emit;
   logic          lastIn;
   logic          fillDone;
   logic          lastWin;
   logic [AW-1:0] lbAddr;
   logic [7:0]    sample;
   logic [7:0]    fillVal;
   logic [7:0]    newCol [3];
   logic [7:0]    win [3][3];
   logic          maskTop;
   logic          maskBot;
   logic          maskLeft;
   logic          maskRight;

   // Handshake decode, line-buffer read and masked window assembly
   always_comb begin
      accept    = iValid & oReady;
      advance   = accept | (state == FLUSH);
      emit      = advance & ((state == RUN) | (state == FLUSH));
      lbAddr    = inCol[AW-1:0];
      sample    = (state == FLUSH) ? 8'd0 : iPixel;
      lastIn    = (inRow == CW'(IMG_H - 1)) && (inCol == CW'(IMG_W - 1));
      fillDone  = (inRow == CW'(1)) && (inCol == CW'(0));
      lastWin   = (cRow == CW'(IMG_H - 1)) && (cCol == CW'(IMG_W - 1));
      maskTop   = (cRow == CW'(0));
      maskBot   = (cRow == CW'(IMG_H - 1));
      maskLeft  = (cCol == CW'(0));
      maskRight = (cCol == CW'(IMG_W - 1));
      newCol[0] = lineB[lbAddr];
      newCol[1] = lineA[lbAddr];
      newCol[2] = sample;
`ifdef WIN_REPLICATE_EN
      fillVal   = tapB[1];
`else
      fillVal   = 8'd0;
`endif
      for (int r = 0; r < 3; r++) begin
         win[r][0] = tapA[r];
         win[r][1] = tapB[r];
         win[r][2] = newCol[r];
      end
      for (int i = 0; i < 3; i++) begin
         if (maskTop)   win[0][i] = fillVal;
         if (maskBot)   win[2][i] = fillVal;
         if (maskLeft)  win[i][0] = fillVal;
         if (maskRight) win[i][2] = fillVal;
      end
   end

   // Line buffers: stale contents after reset are hidden by the masks
   always_ff @(posedge iClk) begin
      if (advance) begin
         lineA[lbAddr] <= sample;
         lineB[lbAddr] <= lineA[lbAddr];
      end
   end

   // Frame control, counters, tap shift and registered window outputs
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state  <= IDLE;
         inRow  <= '0;
         inCol  <= '0;
         cRow   <= '0;
         cCol   <= '0;
         oReady <= 1'b0;
         oValid <= 1'b0;
         oDone  <= 1'b0;
         oRow   <= '0;
         oCol   <= '0;
         oP11   <= 8'd0;
         oP12   <= 8'd0;
         oP13   <= 8'd0;
         oP21   <= 8'd0;
         oP22   <= 8'd0;
         oP23   <= 8'd0;
         oP31   <= 8'd0;
         oP32   <= 8'd0;
         oP33   <= 8'd0;
         for (int i = 0; i < 3; i++) begin
            tapA[i] <= 8'd0;
            tapB[i] <= 8'd0;
         end
      end else begin
         oValid <= 1'b0;
         oDone  <= 1'b0;
         oReady <= 1'b1;

         if (advance) begin
            for (int i = 0; i < 3; i++) begin
               tapA[i] <= tapB[i];
               tapB[i] <= newCol[i];
            end
            if (inCol == CW'(IMG_W - 1)) begin
               inCol <= '0;
               if (state != FLUSH) inRow <= inRow + CW'(1);
            end else begin
               inCol <= inCol + CW'(1);
            end
         end

         if (emit) begin
            oP11   <= win[0][0];
            oP12   <= win[0][1];
            oP13   <= win[0][2];
            oP21   <= win[1][0];
            oP22   <= win[1][1];
            oP23   <= win[1][2];
            oP31   <= win[2][0];
            oP32   <= win[2][1];
            oP33   <= win[2][2];
            oRow   <= cRow;
            oCol   <= cCol;
            oValid <= 1'b1;
            if (cCol == CW'(IMG_W - 1)) begin
               cCol <= '0;
               cRow <= cRow + CW'(1);
            end else begin
               cCol <= cCol + CW'(1);
            end
         end else if (oDone) begin
            oRow <= '0;
            oCol <= '0;
         end

         case (state)
            IDLE:  if (accept) state <= FILL;
            FILL:  if (accept && fillDone) state <= RUN;
            RUN: begin
               if (accept && lastIn) begin
                  state  <= FLUSH;
                  oReady <= 1'b0;
               end
            end
            FLUSH: begin
               if (lastWin) begin
                  state <= IDLE;
                  oDone <= 1'b1;
                  inRow <= '0;
                  inCol <= '0;
                  cRow  <= '0;
                  cCol  <= '0;
               end else begin
                  oReady <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
